// File: rtl/cmd_read.sv
// SD CMD-line response receiver: waits for the card's start bit, deserializes a
// 48-bit or 136-bit response, and checks CRC7, end bit and response index.
module cmd_read #(
    parameter int TimeoutCycles = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_i,
    input  logic         cmd_i,
    input  logic         start_rx_i,
    input  logic         long_rsp_i,
    input  logic         check_crc_i,
    input  logic         check_index_i,
    input  logic [5:0]   cmd_nr_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] rsp_o,
    output logic [5:0]   rsp_index_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_bit_err_o,
    output logic         index_err_o
);

    localparam int WaitW = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        CRC,
        END_BIT,
        DONE
    } state_t;

    state_t         state_reg;
    logic [WaitW-1:0] wait_cnt_reg;
    logic [7:0]     bit_cnt_reg;
    logic [6:0]     crc_reg;
    logic [6:0]     crc_rx_reg;
    logic           long_reg;
    logic           chk_crc_reg;
    logic           chk_idx_reg;
    logic [5:0]     cmd_nr_reg;
    logic [119:0]   rsp_reg;
    logic [5:0]     idx_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           to_err_reg;
    logic           crc_err_reg;
    logic           end_err_reg;
    logic           idx_err_reg;

    logic           crc_fb;
    logic [6:0]     crc_next;
    logic [7:0]     bit_cnt_next;

    // CRC7, x^7 + x^3 + 1, MSB first: shift left, feedback into taps 0 and 3.
    always_comb begin
        crc_fb       = crc_reg[6] ^ cmd_i;
        crc_next     = {crc_reg[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
        bit_cnt_next = bit_cnt_reg + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            crc_reg      <= '0;
            crc_rx_reg   <= '0;
            long_reg     <= 1'b0;
            chk_crc_reg  <= 1'b0;
            chk_idx_reg  <= 1'b0;
            cmd_nr_reg   <= '0;
            rsp_reg      <= '0;
            idx_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            to_err_reg   <= 1'b0;
            crc_err_reg  <= 1'b0;
            end_err_reg  <= 1'b0;
            idx_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_rx_i && clk_en_i) begin
                        long_reg     <= long_rsp_i;
                        chk_crc_reg  <= check_crc_i;
                        chk_idx_reg  <= check_index_i;
                        cmd_nr_reg   <= cmd_nr_i;
                        to_err_reg   <= 1'b0;
                        crc_err_reg  <= 1'b0;
                        end_err_reg  <= 1'b0;
                        idx_err_reg  <= 1'b0;
                        rsp_reg      <= '0;
                        idx_reg      <= '0;
                        crc_reg      <= '0;
                        crc_rx_reg   <= '0;
                        bit_cnt_reg  <= '0;
                        wait_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (clk_en_i) begin
                        if (!cmd_i) begin
                            crc_reg     <= crc_next;
                            bit_cnt_reg <= 8'd1;
                            state_reg   <= RECEIVE;
                        end else if (wait_cnt_reg == WaitW'(TimeoutCycles - 1)) begin
                            to_err_reg <= 1'b1;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                    end
                end
                RECEIVE: begin
                    if (clk_en_i) begin
                        bit_cnt_reg <= bit_cnt_next;
                        // Long responses only protect the CID/CSD body, so the
                        // CRC restarts once the reserved bits have gone by.
                        if (!long_reg || bit_cnt_next >= 8'd9) begin
                            crc_reg <= crc_next;
                        end else if (bit_cnt_next == 8'd8) begin
                            crc_reg <= '0;
                        end
                        if (!long_reg && bit_cnt_next >= 8'd3 && bit_cnt_next <= 8'd8) begin
                            idx_reg <= {idx_reg[4:0], cmd_i};
                        end
                        if (bit_cnt_next >= 8'd9) begin
                            rsp_reg <= {rsp_reg[118:0], cmd_i};
                        end
                        if (bit_cnt_next == (long_reg ? 8'd128 : 8'd40)) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (clk_en_i) begin
                        crc_rx_reg  <= {crc_rx_reg[5:0], cmd_i};
                        bit_cnt_reg <= bit_cnt_next;
                        if (bit_cnt_reg == 8'd6) begin
                            state_reg <= END_BIT;
                        end
                    end
                end
                END_BIT: begin
                    if (clk_en_i) begin
                        end_err_reg <= ~cmd_i;
                        crc_err_reg <= chk_crc_reg && (crc_reg != crc_rx_reg);
                        idx_err_reg <= chk_idx_reg && !long_reg && (idx_reg != cmd_nr_reg);
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign rsp_o         = rsp_reg;
    assign rsp_index_o   = idx_reg;
    assign timeout_err_o = to_err_reg;
    assign crc_err_o     = crc_err_reg;
    assign end_bit_err_o = end_err_reg;
    assign index_err_o   = idx_err_reg;

endmodule
